// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - fetch PC register with hardware return stack and redirect flush.
// Optional STACK_WRAP_EN makes the return stack circular instead of saturating.
module pc_stack_unit #(
  parameter int PC_WIDTH  = 12,
  parameter int DEPTH     = 8,
  parameter int OFS_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_halt,
  input  logic                   i_stall,
  input  logic [1:0]             i_pcSel,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [PC_WIDTH-1:0]    i_jumpAddr,
  input  logic [OFS_WIDTH-1:0]   i_branchOffset,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [PC_WIDTH-1:0]    o_pcPlus1,
  output logic                   o_flush,
  output logic [$clog2(DEPTH):0] o_stackDepth,
  output logic                   o_stackOverflow,
  output logic                   o_stackUnderflow
);
  localparam int AW = $clog2(DEPTH);

  logic [PC_WIDTH-1:0] r_stack [DEPTH];
  logic [PC_WIDTH-1:0] r_pc;
  logic [AW-1:0]       r_wptr;
  logic [AW:0]         r_depth;
  logic                r_flush;
  logic                r_ovf;
  logic                r_unf;

  logic [PC_WIDTH-1:0] w_pc_plus1;
  logic [PC_WIDTH-1:0] w_ofs_ext;
  logic [PC_WIDTH-1:0] w_top;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic                w_accept;
  logic                w_empty;
  logic                w_underflow;
  logic                w_pop_ok;
  logic [AW:0]         w_depth_pop;
  logic [AW-1:0]       w_ptr_pop;
  logic                w_full_pop;
  logic                w_push_wr;
  logic [AW:0]         w_depth_nxt;
  logic [AW-1:0]       w_ptr_nxt;
  logic                w_ovf_set;

  assign w_accept    = ~i_rst & ~i_start & ~i_halt & ~i_stall;
  assign w_pc_plus1  = r_pc + PC_WIDTH'(1);
  assign w_ofs_ext   = {{(PC_WIDTH-OFS_WIDTH){i_branchOffset[OFS_WIDTH-1]}}, i_branchOffset};
  assign w_top       = r_stack[r_wptr - AW'(1)];
  assign w_empty     = (r_depth == '0);
  assign w_underflow = i_pop & w_empty;
  assign w_pop_ok    = i_pop & ~w_empty;

  // Pop is applied first so a simultaneous push sees the post-pop occupancy.
  assign w_depth_pop = r_depth - (AW+1)'(w_pop_ok);
  assign w_ptr_pop   = r_wptr - AW'(w_pop_ok);
  assign w_full_pop  = (w_depth_pop == (AW+1)'(DEPTH));

`ifdef STACK_WRAP_EN
  assign w_push_wr   = i_push;
  assign w_depth_nxt = (i_push & ~w_full_pop) ? w_depth_pop + (AW+1)'(1) : w_depth_pop;
  assign w_ptr_nxt   = w_ptr_pop + AW'(i_push);
  assign w_ovf_set   = 1'b0;
`else
  assign w_push_wr   = i_push & ~w_full_pop;
  assign w_depth_nxt = w_depth_pop + (AW+1)'(w_push_wr);
  assign w_ptr_nxt   = w_ptr_pop + AW'(w_push_wr);
  assign w_ovf_set   = i_push & w_full_pop;
`endif

  always_comb begin
    w_next_pc = w_pc_plus1;
    if (!w_underflow) begin
      case (i_pcSel)
        2'd1:    w_next_pc = i_jumpAddr;
        2'd2:    w_next_pc = w_top;
        2'd3:    w_next_pc = r_pc + w_ofs_ext;
        default: w_next_pc = w_pc_plus1;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc    <= '0;
      r_wptr  <= '0;
      r_depth <= '0;
      r_flush <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (i_start) begin
      r_pc    <= '0;
      r_wptr  <= '0;
      r_depth <= '0;
      r_flush <= 1'b0;
    end else if (i_halt || i_stall) begin
      r_flush <= 1'b0;
    end else begin
      r_pc    <= w_next_pc;
      r_wptr  <= w_ptr_nxt;
      r_depth <= w_depth_nxt;
      r_flush <= (i_pcSel != 2'd0);
      r_ovf   <= r_ovf | w_ovf_set;
      r_unf   <= r_unf | w_underflow;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && w_push_wr) r_stack[w_ptr_pop] <= w_pc_plus1;
  end

  assign o_pc             = r_pc;
  assign o_pcPlus1        = w_pc_plus1;
  assign o_flush          = r_flush;
  assign o_stackDepth     = r_depth;
  assign o_stackOverflow  = r_ovf;
  assign o_stackUnderflow = r_unf;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed plus randomized check of pc_stack_unit against a queue model.
module tb_pc_stack_unit;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, start, halt, stall, push, pop;
  logic [1:0]  pc_sel;
  logic [11:0] jump_addr;
  logic [7:0]  branch_ofs;
  logic [11:0] pc, pc_plus1;
  logic        flush, ovf, unf;
  logic [3:0]  depth;

  int n_cmp = 0;
  int n_err = 0;

  int m_pc = 0;
  int m_q[$];
  bit m_flush = 0, m_ovf = 0, m_unf = 0;

  always #5 clk = ~clk;

  pc_stack_unit #(.PC_WIDTH(12), .DEPTH(DEPTH), .OFS_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt(halt), .i_stall(stall),
    .i_pcSel(pc_sel), .i_push(push), .i_pop(pop), .i_jumpAddr(jump_addr),
    .i_branchOffset(branch_ofs), .o_pc(pc), .o_pcPlus1(pc_plus1), .o_flush(flush),
    .o_stackDepth(depth), .o_stackOverflow(ovf), .o_stackUnderflow(unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the return stack is a queue of addresses, top at the back.
  task automatic model_edge(input bit r, st, hl, sl, input int sel, input bit ps, pp,
                            input int ja, input logic [7:0] ofs);
    int  tgt, np;
    bit  unf_now;
    if (r) begin
      m_pc = 0; m_q.delete(); m_flush = 0; m_ovf = 0; m_unf = 0;
    end else if (st) begin
      m_pc = 0; m_q.delete(); m_flush = 0;
    end else if (hl || sl) begin
      m_flush = 0;
    end else begin
      unf_now = pp && (m_q.size() == 0);
      tgt = 0;
      if (pp && !unf_now) tgt = m_q.pop_back();
      else if (m_q.size() > 0) tgt = m_q[$];
      case (sel)
        1:       np = ja;
        2:       np = tgt;
        3:       np = m_pc + int'($signed(ofs));
        default: np = m_pc + 1;
      endcase
      if (unf_now) np = m_pc + 1;
      if (ps) begin
        if (m_q.size() < DEPTH) m_q.push_back((m_pc + 1) & 'hFFF);
        else begin
`ifdef STACK_WRAP_EN
          void'(m_q.pop_front());
          m_q.push_back((m_pc + 1) & 'hFFF);
`else
          m_ovf = 1;
`endif
        end
      end
      m_flush = (sel != 0);
      m_unf   = m_unf | unf_now;
      m_pc    = np & 'hFFF;
    end
  endtask

  task automatic step(input bit r, st, hl, sl, input int sel, input bit ps, pp,
                      input int ja, input logic [7:0] ofs);
    rst = r; start = st; halt = hl; stall = sl; pc_sel = 2'(sel);
    push = ps; pop = pp; jump_addr = 12'(ja); branch_ofs = ofs;
    #1;
    check("pcPlus1", 32'(pc_plus1), 32'((m_pc + 1) & 'hFFF));
    model_edge(r, st, hl, sl, sel, ps, pp, ja, ofs);
    @(posedge clk);
    #1;
    check("pc", 32'(pc), 32'(m_pc));
    check("depth", 32'(depth), 32'(m_q.size()));
    check("flush", 32'(flush), 32'(m_flush));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("unf", 32'(unf), 32'(m_unf));
  endtask

  task automatic run(input int sel, input bit ps, pp, input int ja, input logic [7:0] ofs);
    step(0, 0, 0, 0, sel, ps, pp, ja, ofs);
  endtask

  initial begin
    int sel;
    bit ps, pp;
    rst = 1; start = 0; halt = 0; stall = 0; pc_sel = 0; push = 0; pop = 0;
    jump_addr = 0; branch_ofs = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    check("rst_pc", 32'(pc), 0);
    check("rst_depth", 32'(depth), 0);

    for (int i = 0; i < 10; i++) run(0, 0, 0, 0, 8'h00);
    check("pc_at_10", 32'(pc), 10);
    run(1, 1, 0, 'h200, 8'h00);
    check("call_pc", 32'(pc), 'h200);
    check("call_flush", 32'(flush), 1);
    run(0, 0, 0, 0, 8'h00);
    check("flush_one_cycle", 32'(flush), 0);
    run(2, 0, 1, 0, 8'h00);
    check("ret_pc", 32'(pc), 11);
    check("ret_depth", 32'(depth), 0);

    run(1, 0, 0, 2, 8'h00);
    run(3, 0, 0, 0, 8'hFD);
    check("branch_wrap", 32'(pc), 'hFFF);
    run(0, 0, 0, 0, 8'h00);
    check("pc_wrap", 32'(pc), 0);

    for (int i = 0; i < 9; i++) run(1, 1, 0, 'h100 + 16 * i, 8'h00);
    check("nest_depth", 32'(depth), DEPTH);
    for (int i = 0; i < 8; i++) run(2, 0, 1, 0, 8'h00);
    check("nest_empty", 32'(depth), 0);

    run(1, 0, 0, 7, 8'h00);
    run(2, 0, 1, 0, 8'h00);
    check("unf_pc", 32'(pc), 8);
    check("unf_flag", 32'(unf), 1);
    run(0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 3; i++) run(1, 1, 0, 'h300 + i, 8'h00);
    step(0, 0, 0, 1, 1, 1, 0, 'h555, 8'h00);
    step(0, 0, 1, 0, 3, 0, 1, 0, 8'h10);
    step(0, 1, 0, 0, 1, 1, 0, 'h123, 8'h00);
    check("start_depth", 32'(depth), 0);
    check("start_unf_kept", 32'(unf), 1);

    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 3);
      ps  = ($urandom_range(0, 2) == 0);
      pp  = ($urandom_range(0, 2) == 0);
      if (sel == 2 && m_q.size() == 0) pp = 1;
      step($urandom_range(0, 255) == 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           sel, ps, pp, $urandom_range(0, 4095), 8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
